regfile_write_port: RTL and testbench

REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

---
 rtl/regfile_pkg.sv | 13 +
 rtl/wr_decoder_5to32.sv | 15 +
 rtl/regfile_write_port.sv | 102 ++++++++++
 tb/tb_regfile_write_port.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and pending-write entry type for the register-file write port
package regfile_pkg;

  localparam int ADDR_W         = 5;
  localparam int NUM_REGS       = 32;
  localparam int DEFAULT_DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]         addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/wr_decoder_5to32.sv
// rtl/wr_decoder_5to32.sv - commit address plus enable to one-hot register write-enable vector
module wr_decoder_5to32
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_we
);

  always_comb begin
    o_we = '0;
    if (i_en) o_we[i_addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_port.sv
// rtl/regfile_write_port.sv - queued register-file write port with hazard lookup; macro REGFILE_ZERO_HARDWIRED_EN hardwires r0
// Queue entries carry DEFAULT_DATA_W data bits, so DATA_W must not exceed DEFAULT_DATA_W.
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       stall_i,
  input  logic [ADDR_W-1:0]          chk_addr_i,
  output logic                       hazard_o,
  output logic                       commit_o,
  output logic [ADDR_W-1:0]          commit_addr_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int PTR_W = $clog2(DEPTH);

`ifdef REGFILE_ZERO_HARDWIRED_EN
  localparam bit ZERO_HW = 1'b1;
`else
  localparam bit ZERO_HW = 1'b0;
`endif

  wq_entry_t          r_q [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic [DATA_W-1:0]  r_regs [NUM_REGS];
  logic               r_commit;
  logic [ADDR_W-1:0]  r_commit_addr;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_hit;
  logic [NUM_REGS-1:0] w_we;

  assign wr_ready_o = rst_n_i && (r_count < (PTR_W+1)'(DEPTH));
  assign w_accept   = wr_valid_i && wr_ready_o;
  // r0 writes are acknowledged but dropped when r0 is hardwired
  assign w_push     = w_accept && !(ZERO_HW && (wr_addr_i == '0));
  assign w_pop      = (r_count != '0) && !stall_i;

  wr_decoder_5to32 u_dec (
    .i_addr (r_q[r_head].addr),
    .i_en   (w_pop),
    .o_we   (w_we)
  );

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(PTR_W'(i) - r_head)} < r_count) && (r_q[i].addr == chk_addr_i))
        w_hit = 1'b1;
    end
  end

  assign hazard_o = rst_n_i && w_hit && !(ZERO_HW && (chk_addr_i == '0));

  always_ff @(posedge clk_i) begin
    if (w_push) r_q[r_tail] <= '{addr: wr_addr_i, data: DEFAULT_DATA_W'(wr_data_i)};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_commit      <= 1'b0;
      r_commit_addr <= '0;
      for (int n = 0; n < NUM_REGS; n++) r_regs[n] <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      r_commit <= w_pop;
      if (w_pop) r_commit_addr <= r_q[r_head].addr;
      for (int n = 0; n < NUM_REGS; n++) begin
        if (w_we[n] && !(ZERO_HW && (n == 0))) r_regs[n] <= r_q[r_head].data[DATA_W-1:0];
      end
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs
    assign regs_o[n*DATA_W +: DATA_W] = r_regs[n];
  end

  assign commit_o      = r_commit;
  assign commit_addr_o = r_commit_addr;

endmodule

// File: tb/tb_regfile_write_port.sv
// tb/tb_regfile_write_port.sv - randomized self-checking bench with a queue-based reference model
module tb_regfile_write_port;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
`ifdef REGFILE_ZERO_HARDWIRED_EN
  localparam bit ZERO_HW = 1'b1;
`else
  localparam bit ZERO_HW = 1'b0;
`endif

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [4:0]     wr_addr  = '0;
  logic [DW-1:0]  wr_data  = '0;
  logic           stall    = 1'b0;
  logic [4:0]     chk_addr = '0;
  logic           hazard;
  logic           commit;
  logic [4:0]     commit_addr;
  logic [32*DW-1:0] regs;

  always #5 clk = ~clk;

  regfile_write_port #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .stall_i       (stall),
    .chk_addr_i    (chk_addr),
    .hazard_o      (hazard),
    .commit_o      (commit),
    .commit_addr_o (commit_addr),
    .regs_o        (regs)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_regs [32];
  logic [4:0]    m_qa [$];
  logic [DW-1:0] m_qd [$];
  logic          m_commit      = 1'b0;
  logic [4:0]    m_commit_addr = '0;

  function automatic logic exp_ready();
    return rst_n && (m_qa.size() < DEPTH);
  endfunction

  function automatic logic exp_hazard();
    if (!rst_n || (ZERO_HW && chk_addr == 5'd0)) return 1'b0;
    foreach (m_qa[i]) if (m_qa[i] == chk_addr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int first_diff();
    for (int n = 0; n < 32; n++) if (regs[n*DW +: DW] !== m_regs[n]) return n;
    return -1;
  endfunction

  // One clock edge: the model applies commit-then-accept on the values the DUT sees at the edge.
  task automatic step();
    logic acc;
    @(posedge clk);
    if (!rst_n) begin
      m_qa.delete();
      m_qd.delete();
      for (int n = 0; n < 32; n++) m_regs[n] = '0;
      m_commit      = 1'b0;
      m_commit_addr = '0;
    end else begin
      acc = wr_valid && (m_qa.size() < DEPTH);
      m_commit = 1'b0;
      if (m_qa.size() > 0 && !stall) begin
        m_regs[m_qa[0]] = m_qd[0];
        m_commit        = 1'b1;
        m_commit_addr   = m_qa[0];
        void'(m_qa.pop_front());
        void'(m_qd.pop_front());
      end
      if (acc && !(ZERO_HW && wr_addr == 5'd0)) begin
        m_qa.push_back(wr_addr);
        m_qd.push_back(wr_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0; stall = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int d;
    rst_n = 1'b0; wr_valid = 1'b0; stall = 1'b0; chk_addr = 5'd0;
    step();
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b expected 0", wr_ready); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
    n_checks++; if (commit !== 1'b0 || commit_addr !== 5'd0) begin n_fail++; $display("FAIL reset_commit: got %b/%0d expected 0/0", commit, commit_addr); end
    d = first_diff();
    n_checks++; if (regs !== '0 || d >= 0) begin n_fail++; $display("FAIL reset_regs: some register nonzero (first diff %0d)", d); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release: got %b expected 1", wr_ready); end
  endtask

  task automatic test_single_write();
    int d;
    do_reset();
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; stall = 1'b0;
    step();
    wr_valid = 1'b0;
    #1;
    n_checks++; if (commit !== 1'b0) begin n_fail++; $display("FAIL single_no_early_commit: got %b expected 0", commit); end
    step();
    #1;
    n_checks++; if (commit !== 1'b1 || commit_addr !== 5'd5) begin n_fail++; $display("FAIL single_commit: got %b/%0d expected 1/5", commit, commit_addr); end
    n_checks++; if (regs[5*DW +: DW] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_reg5: got %h expected deadbeef", regs[5*DW +: DW]); end
    d = first_diff();
    n_checks++; if (d >= 0) begin n_fail++; $display("FAIL single_regs: reg %0d got %h expected %h", d, regs[d*DW +: DW], m_regs[d]); end
    step();
    #1;
    n_checks++; if (commit !== 1'b0 || commit_addr !== 5'd5) begin n_fail++; $display("FAIL single_pulse: got %b/%0d expected 0/5", commit, commit_addr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    stall = 1'b1; wr_valid = 1'b1;
    wr_addr = 5'd1; wr_data = $urandom; step();
    wr_addr = 5'd2; wr_data = $urandom; step();
    wr_valid = 1'b0; chk_addr = 5'd2;
    #1;
    n_checks++; if (wr_ready !== 1'b0 || wr_ready !== exp_ready()) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", wr_ready); end
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL bp_hazard_2: got %b expected 1", hazard); end
    chk_addr = 5'd3;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL bp_hazard_3: got %b expected 0", hazard); end
    stall = 1'b0;
    step(); #1;
    n_checks++; if (commit !== 1'b1 || commit_addr !== 5'd1) begin n_fail++; $display("FAIL bp_commit1: got %b/%0d expected 1/1", commit, commit_addr); end
    step(); #1;
    n_checks++; if (commit !== 1'b1 || commit_addr !== 5'd2) begin n_fail++; $display("FAIL bp_commit2: got %b/%0d expected 1/2", commit, commit_addr); end
    n_checks++; if (regs[2*DW +: DW] !== m_regs[2] || regs[1*DW +: DW] !== m_regs[1]) begin n_fail++; $display("FAIL bp_regs: got %h/%h expected %h/%h", regs[1*DW +: DW], regs[2*DW +: DW], m_regs[1], m_regs[2]); end
    step(); #1;
    n_checks++; if (commit !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drained: got commit %b ready %b expected 0 1", commit, wr_ready); end
  endtask

  task automatic test_same_addr();
    do_reset();
    wr_valid = 1'b1; wr_addr = 5'd7;
    wr_data = 32'h1; step();
    wr_data = 32'h2; step();
    wr_valid = 1'b0;
    repeat (3) step();
    #1;
    n_checks++; if (regs[7*DW +: DW] !== 32'h2) begin n_fail++; $display("FAIL same_addr_reg7: got %h expected 2", regs[7*DW +: DW]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stall = 1'b1; wr_valid = 1'b1;
    wr_addr = 5'd3; wr_data = $urandom; step();
    wr_addr = 5'd4; wr_data = $urandom; step();
    wr_valid = 1'b0; rst_n = 1'b0; chk_addr = 5'd3;
    step(); #1;
    n_checks++; if (commit !== 1'b0) begin n_fail++; $display("FAIL rstmid_commit: got %b expected 0", commit); end
    n_checks++; if (wr_ready !== 1'b0 || hazard !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_reset: got ready %b hazard %b expected 0 0", wr_ready, hazard); end
    rst_n = 1'b1; stall = 1'b0;
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_release: got %b expected 1", wr_ready); end
    step(); step(); #1;
    n_checks++; if (commit !== 1'b0 || regs !== '0) begin n_fail++; $display("FAIL rstmid_discard: commit %b reg3 %h reg4 %h expected 0 0 0", commit, regs[3*DW +: DW], regs[4*DW +: DW]); end
  endtask

  task automatic test_addr_zero();
    do_reset();
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF; chk_addr = 5'd0;
    step();
    wr_valid = 1'b0;
    #1;
    n_checks++; if (hazard !== !ZERO_HW) begin n_fail++; $display("FAIL zero_hazard: got %b expected %b", hazard, !ZERO_HW); end
    step(); #1;
    n_checks++; if (commit !== !ZERO_HW) begin n_fail++; $display("FAIL zero_commit: got %b expected %b", commit, !ZERO_HW); end
    n_checks++; if (regs[DW-1:0] !== (ZERO_HW ? 32'h0 : 32'hFFFF)) begin n_fail++; $display("FAIL zero_reg0: got %h expected %h", regs[DW-1:0], ZERO_HW ? 32'h0 : 32'hFFFF); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] vals [10];
    int idx = 0;
    int ncommit = 0;
    int cyc = 0;
    logic acc;
    do_reset();
    while ((idx < 10 || m_qa.size() > 0) && cyc < 200) begin
      if (idx < 10) begin
        if (!wr_valid || wr_addr != 5'(10 + idx)) vals[idx] = $urandom;
        wr_valid = 1'b1; wr_addr = 5'(10 + idx); wr_data = vals[idx];
      end else begin
        wr_valid = 1'b0;
      end
      stall = cyc[0];
      #1;
      n_checks++; if (wr_ready !== exp_ready()) begin n_fail++; $display("FAIL wrap_ready: cycle %0d got %b expected %b", cyc, wr_ready, exp_ready()); end
      acc = wr_valid && exp_ready();
      step();
      if (acc) idx++;
      #1;
      n_checks++; if (commit !== m_commit) begin n_fail++; $display("FAIL wrap_commit: cycle %0d got %b expected %b", cyc, commit, m_commit); end
      if (m_commit) begin
        n_checks++; if (commit_addr !== 5'(10 + ncommit)) begin n_fail++; $display("FAIL wrap_order: got %0d expected %0d", commit_addr, 10 + ncommit); end
        ncommit++;
      end
      cyc++;
    end
    wr_valid = 1'b0; stall = 1'b0;
    n_checks++; if (cyc >= 200 || ncommit != 10) begin n_fail++; $display("FAIL wrap_count: got %0d commits in %0d cycles expected 10", ncommit, cyc); end
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (regs[(10+k)*DW +: DW] !== vals[k]) begin n_fail++; $display("FAIL wrap_reg%0d: got %h expected %h", 10 + k, regs[(10+k)*DW +: DW], vals[k]); end
    end
  endtask

  task automatic test_random();
    int d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      wr_valid = $urandom_range(0, 1);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      chk_addr = (m_qa.size() > 0 && $urandom_range(0, 1)) ? m_qa[0] : 5'($urandom_range(0, 31));
      #1;
      n_checks++; if (wr_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %b expected %b", c, wr_ready, exp_ready()); end
      n_checks++; if (hazard !== exp_hazard()) begin n_fail++; $display("FAIL rand_hazard: cycle %0d chk %0d got %b expected %b", c, chk_addr, hazard, exp_hazard()); end
      step(); #1;
      n_checks++; if (commit !== m_commit || commit_addr !== m_commit_addr) begin n_fail++; $display("FAIL rand_commit: cycle %0d got %b/%0d expected %b/%0d", c, commit, commit_addr, m_commit, m_commit_addr); end
      d = first_diff();
      n_checks++; if (d >= 0) begin n_fail++; $display("FAIL rand_regs: cycle %0d reg %0d got %h expected %h", c, d, regs[d*DW +: DW], m_regs[d]); end
    end
    rst_n = 1'b1; wr_valid = 1'b0; stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 32; n++) m_regs[n] = '0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_backpressure();
    test_same_addr();
    test_reset_mid();
    test_addr_zero();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
